massbus_regseq: RTL and testbench

//   Sequences RH11 drive-register accesses onto the Massbus register port.

---
 rtl/massbus_regseq.sv | 159 +++++++++++++++
 tb/tb_massbus_regseq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/massbus_regseq.sv
// massbus_regseq: sequences one RH11 drive-register read or write onto the
// Massbus register port and reports completion as ACK or non-existent drive (NED).
// Latency: accept edge to done pulse is 3+k cycles (k = ack delay after strobe); absent drive 2.
// Backpressure: requests are held by the requester until doneACK/doneNED; no new accept while busy.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   init                controller clear: abort to IDLE, NED pulse if mid-transaction
//   reqREAD/reqWRITE    request strobes (read wins if both), with reqUNIT/reqREGSEL/reqDATA
//   busy                transaction in progress
//   doneACK/doneNED     one-cycle completion pulses; doneDATA holds the last read data
//   mbUNIT/mbREGSEL     Massbus drive/register select, stable from SETUP through DONE
//   mbDATAI             Massbus write data (low 16 bits), only during a write strobe
//   mbREAD/mbWRITE      one-cycle register strobes
//   mbDPR/mbREGACK      drive present / register acknowledge; mbREGDAT read data
module massbus_regseq #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        reqREAD,
  input  logic        reqWRITE,
  input  logic [2:0]  reqUNIT,
  input  logic [4:0]  reqREGSEL,
  input  logic [15:0] reqDATA,
  output logic        busy,
  output logic        doneACK,
  output logic        doneNED,
  output logic [15:0] doneDATA,
  output logic [2:0]  mbUNIT,
  output logic [4:0]  mbREGSEL,
  output logic [35:0] mbDATAI,
  output logic        mbREAD,
  output logic        mbWRITE,
  input  logic        mbDPR,
  input  logic        mbREGACK,
  input  logic [15:0] mbREGDAT
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    WAITACK = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state, stateNext;
  logic [2:0]  unitQ;
  logic [4:0]  regselQ;
  logic [15:0] dataQ;
  logic        writeQ;
  logic [7:0]  count, countNext;
  logic        ackNext, nedNext;
  logic [15:0] doneDataNext;
  logic        accept;
  logic        strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      unitQ    <= '0;
      regselQ  <= '0;
      dataQ    <= '0;
      writeQ   <= 1'b0;
      count    <= '0;
      doneACK  <= 1'b0;
      doneNED  <= 1'b0;
      doneDATA <= '0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      doneACK  <= ackNext;
      doneNED  <= nedNext;
      doneDATA <= doneDataNext;
      if (accept) begin
        unitQ   <= reqUNIT;
        regselQ <= reqREGSEL;
        dataQ   <= reqDATA;
        writeQ  <= !reqREAD;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    countNext    = count;
    ackNext      = 1'b0;
    nedNext      = 1'b0;
    doneDataNext = doneDATA;
    accept       = 1'b0;
    if (init) begin
      // Abort: only a transaction that has not yet reported needs an NED pulse.
      stateNext = IDLE;
      nedNext   = (state != IDLE) && (state != DONE);
    end else begin
      case (state)
        IDLE: begin
          // An init-abort NED pulse is shown in IDLE; the requester is still
          // holding req during that cycle, so do not re-accept it.
          if ((reqREAD || reqWRITE) && !doneNED) begin
            accept    = 1'b1;
            stateNext = SETUP;
          end
        end
        SETUP: begin
          if (!mbDPR) begin
            stateNext = DONE;
            nedNext   = 1'b1;
          end else begin
            stateNext = STROBE;
          end
        end
        STROBE: begin
          if (mbREGACK) begin
            stateNext = DONE;
            ackNext   = 1'b1;
            if (!writeQ) doneDataNext = mbREGDAT;
          end else begin
            stateNext = WAITACK;
            countNext = '0;
          end
        end
        WAITACK: begin
          // Ack is checked before timeout so a coincident ack wins.
          if (mbREGACK) begin
            stateNext = DONE;
            ackNext   = 1'b1;
            if (!writeQ) doneDataNext = mbREGDAT;
          end else if (count == TMO) begin
            stateNext = DONE;
            nedNext   = 1'b1;
          end else begin
            countNext = count + 8'd1;
          end
        end
        DONE: begin
          stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // Strobes are dropped immediately when init arrives during STROBE.
  assign strobe   = (state == STROBE) && !init;
  assign busy     = (state != IDLE);
  assign mbUNIT   = busy ? unitQ : 3'd0;
  assign mbREGSEL = busy ? regselQ : 5'd0;
  assign mbREAD   = strobe && !writeQ;
  assign mbWRITE  = strobe && writeQ;
  assign mbDATAI  = (strobe && writeQ) ? {20'd0, dataQ} : 36'd0;

endmodule

// File: tb/tb_massbus_regseq.sv
// tb_massbus_regseq: scoreboard bench for massbus_regseq with a behavioural
// drive responder; expected completions are queued at issue time and popped
// by an independent monitor whenever a done pulse appears.
module tb_massbus_regseq;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, init, reqREAD, reqWRITE;
  logic [2:0]  reqUNIT;
  logic [4:0]  reqREGSEL;
  logic [15:0] reqDATA;
  logic        busy, doneACK, doneNED;
  logic [15:0] doneDATA;
  logic [2:0]  mbUNIT;
  logic [4:0]  mbREGSEL;
  logic [35:0] mbDATAI;
  logic        mbREAD, mbWRITE;
  logic        mbDPR, mbREGACK;
  logic [15:0] mbREGDAT;

  massbus_regseq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .init(init),
    .reqREAD(reqREAD), .reqWRITE(reqWRITE), .reqUNIT(reqUNIT),
    .reqREGSEL(reqREGSEL), .reqDATA(reqDATA),
    .busy(busy), .doneACK(doneACK), .doneNED(doneNED), .doneDATA(doneDATA),
    .mbUNIT(mbUNIT), .mbREGSEL(mbREGSEL), .mbDATAI(mbDATAI),
    .mbREAD(mbREAD), .mbWRITE(mbWRITE),
    .mbDPR(mbDPR), .mbREGACK(mbREGACK), .mbREGDAT(mbREGDAT)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ack;
    logic [15:0] data;
    int          doneCyc;
  } exp_t;
  exp_t expQ[$];

  logic [15:0] modelData = 16'd0;
  logic [2:0]  curUnit = 3'd0;
  logic [4:0]  curReg = 5'd0;
  logic [15:0] curData = 16'd0;
  bit          curWrite = 1'b0;
  int          curK = -1;
  int          strobeCnt = 0;
  bit          ackPend = 1'b0;
  int          ackCd = 0;

  function automatic logic [64:0] outVec();
    return {busy, doneACK, doneNED, doneDATA, mbUNIT, mbREGSEL, mbDATAI, mbREAD, mbWRITE};
  endfunction

  // Drive model: checks each strobe and answers with mbREGACK k cycles later
  // (k=0 answers inside the strobe cycle; k<0 never answers).
  initial begin : responder
    forever begin
      @(negedge clk);
      mbREGACK = 1'b0;
      if (rst) begin
        ackPend = 1'b0;
      end else begin
        if (mbREAD || mbWRITE) begin
          strobeCnt++;
          checks++;
          if (mbREAD !== !curWrite || mbWRITE !== curWrite || mbUNIT !== curUnit ||
              mbREGSEL !== curReg ||
              mbDATAI !== (curWrite ? {20'd0, curData} : 36'd0)) begin
            errors++;
            $display("FAIL strobe: got rd=%b wr=%b unit=%0d reg=%0o dati=%h, expected rd=%b wr=%b unit=%0d reg=%0o dati=%h",
                     mbREAD, mbWRITE, mbUNIT, mbREGSEL, mbDATAI, !curWrite, curWrite,
                     curUnit, curReg, curWrite ? {20'd0, curData} : 36'd0);
          end
          if (curK >= 0) begin
            ackPend = 1'b1;
            ackCd   = curK;
          end
        end
        if (ackPend) begin
          if (ackCd == 0) begin
            mbREGACK = 1'b1;
            ackPend  = 1'b0;
          end else begin
            ackCd--;
          end
        end
      end
    end
  end

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (doneACK || doneNED)) begin
        checks++;
        if (doneACK && doneNED) begin
          errors++;
          $display("FAIL doneBoth: got ack=1 ned=1, expected exactly one");
        end
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedDone: got ack=%b ned=%b at cycle %0d, expected none",
                   doneACK, doneNED, cyc);
        end else begin
          e = expQ.pop_front();
          checks++;
          if (doneACK !== e.ack || doneNED !== !e.ack) begin
            errors++;
            $display("FAIL doneKind: got ack=%b ned=%b, expected ack=%b ned=%b",
                     doneACK, doneNED, e.ack, !e.ack);
          end
          checks++;
          if (doneDATA !== e.data) begin
            errors++;
            $display("FAIL doneData: got %h, expected %h", doneDATA, e.data);
          end
          checks++;
          if (cyc != e.doneCyc) begin
            errors++;
            $display("FAIL doneTiming: got cycle %0d, expected cycle %0d", cyc, e.doneCyc);
          end
        end
      end
    end
  end

  // Reference model: outcome and latency from drive presence and ack delay.
  task automatic pushExp(input bit isWr, input bit dpr, input int k,
                         input logic [15:0] rdat, input int acc);
    exp_t e;
    int   lat;
    bit   ack;
    ack = dpr && (k >= 0) && (k <= TMO + 1);
    if (!dpr)     lat = 2;
    else if (ack) lat = 3 + k;
    else          lat = 4 + TMO;
    if (ack && !isWr) modelData = rdat;
    e.ack     = ack;
    e.data    = modelData;
    e.doneCyc = acc + lat - 1;
    expQ.push_back(e);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (doneACK || doneNED) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL doneTimeout: got no done pulse in 40 cycles, expected one");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkStrobes(input int expCnt);
    checks++;
    if (strobeCnt != expCnt) begin
      errors++;
      $display("FAIL strobeCount: got %0d, expected %0d", strobeCnt, expCnt);
    end
  endtask

  task automatic checkIdle(input string name);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%b, expected 0", name, busy);
    end
  endtask

  task automatic runTxn(input bit rd, input bit wr, input logic [2:0] u, input logic [4:0] r,
                        input logic [15:0] d, input bit dpr, input int k,
                        input logic [15:0] rdat);
    curUnit = u; curReg = r; curData = d; curK = k; curWrite = !rd;
    strobeCnt = 0;
    mbDPR = dpr; mbREGDAT = rdat;
    @(negedge clk);
    reqUNIT = u; reqREGSEL = r; reqDATA = d; reqREAD = rd; reqWRITE = wr;
    pushExp(!rd, dpr, k, rdat, cyc + 1);
    waitDone();
    reqREAD = 1'b0;
    checkStrobes(dpr ? 1 : 0);
    if (rd && wr) begin
      // The write stays pending and is accepted at the next edge.
      curWrite = 1'b1;
      strobeCnt = 0;
      pushExp(1'b1, dpr, k, rdat, cyc + 1);
      waitDone();
      checkStrobes(dpr ? 1 : 0);
    end
    reqWRITE = 1'b0;
    @(negedge clk);
    checkIdle("idleAfterDone");
  endtask

  initial begin : stim
    int a;
    rst = 1'b1; init = 1'b0; reqREAD = 1'b0; reqWRITE = 1'b0;
    reqUNIT = 3'd0; reqREGSEL = 5'd0; reqDATA = 16'd0;
    mbDPR = 1'b0; mbREGDAT = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (outVec() !== 65'd0) begin
      errors++;
      $display("FAIL resetOutputs: got %h, expected 0", outVec());
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    runTxn(1'b1, 1'b0, 3'd2, 5'o06, 16'h0000, 1'b1, 2, 16'o123456);
    runTxn(1'b0, 1'b1, 3'd0, 5'd0, 16'hA5C3, 1'b1, 0, 16'h1111);
    runTxn(1'b1, 1'b0, 3'd7, 5'o12, 16'h0000, 1'b0, 0, 16'h2222);
    runTxn(1'b1, 1'b0, 3'd3, 5'o01, 16'h0000, 1'b1, -1, 16'h3333);
    runTxn(1'b1, 1'b0, 3'd3, 5'o01, 16'h0000, 1'b1, TMO + 1, 16'h4444);
    runTxn(1'b1, 1'b1, 3'd5, 5'o17, 16'hBEEF, 1'b1, 1, 16'h5555);

    // init while waiting for ack: one NED pulse, then a late ack is ignored.
    curUnit = 3'd4; curReg = 5'o03; curData = 16'h0; curK = 4; curWrite = 1'b0;
    strobeCnt = 0; mbDPR = 1'b1; mbREGDAT = 16'h6666;
    @(negedge clk);
    reqUNIT = 3'd4; reqREGSEL = 5'o03; reqDATA = 16'h0; reqREAD = 1'b1;
    a = cyc + 1;
    expQ.push_back('{ack: 1'b0, data: modelData, doneCyc: a + 3});
    repeat (3) @(negedge clk);
    init = 1'b1;
    waitDone();
    reqREAD = 1'b0; init = 1'b0;
    repeat (6) @(negedge clk);
    checkIdle("idleAfterInit");
    checkStrobes(1);

    // Reset while waiting for ack: outputs clear, no done pulse.
    curUnit = 3'd6; curReg = 5'o05; curK = -1; curWrite = 1'b0;
    strobeCnt = 0; mbREGDAT = 16'h7777;
    @(negedge clk);
    reqUNIT = 3'd6; reqREGSEL = 5'o05; reqREAD = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; reqREAD = 1'b0;
    @(negedge clk);
    checks++;
    if (outVec() !== 65'd0) begin
      errors++;
      $display("FAIL midWaitReset: got %h, expected 0", outVec());
    end
    rst = 1'b0;
    modelData = 16'd0;
    repeat (8) @(negedge clk);
    checkIdle("idleAfterReset");

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int dir;
      dir = int'($urandom_range(0, 2));
      runTxn(dir != 1, dir != 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             16'($urandom), $urandom_range(0, 7) != 0, int'($urandom_range(0, 7)) - 1,
             16'($urandom));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL pendingExpect: got %0d outstanding, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
